// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// The WIDTH-bit word is cut into NSEG segments of SEG bits, and each pipeline stage
// resolves one segment. A segment is a set of 4-bit CLA groups joined by a flat
// group-level lookahead. The carry between segments is registered. Operands skew
// forward through the stages alongside the partial sum and the running word P/G.
// One global advance enable (in_ready) moves every stage together, giving full
// backpressure with single-cycle throughput.
// WIDTH must be a multiple of SEG, SEG a multiple of 4, and WIDTH/SEG >= 1.

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_pg,
    output logic             out_gg
);

    localparam int NSEG = WIDTH / SEG;  // pipeline depth = latency in cycles
    localparam int NGRP = SEG / 4;      // 4-bit CLA groups per segment

    // carry[i] is the carry into bit i of the group; carry[0] is the group carry-in
    typedef struct packed {
        logic [3:0] carry;
        logic       pg;
        logic       gg;
    } grp_t;

    typedef struct packed {
        logic [SEG-1:0] sum;
        logic           cout;     // carry out of the segment MSB
        logic           msb_cin;  // carry into the segment MSB (used for overflow)
        logic           pg;
        logic           gg;
    } seg_t;

    // Single 4-bit CLA group: internal carries, group propagate/generate
    function automatic grp_t cla_group(input logic [3:0] p, input logic [3:0] g,
                                       input logic cin);
        grp_t r;
        r.carry[0] = cin;
        r.carry[1] = g[0] | (p[0] & cin);
        r.carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        r.carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cin);
        r.gg       = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
        r.pg       = &p;
        return r;
    endfunction

    // One segment: group P/G first, then every group carry-in is expanded as a
    // flat sum-of-products over the lower groups, so no carry ripples group to group
    function automatic seg_t cla_segment(input logic [SEG-1:0] p, input logic [SEG-1:0] g,
                                         input logic cin);
        seg_t            r;
        grp_t            grp;
        logic [NGRP-1:0] grp_pg;
        logic [NGRP-1:0] grp_gg;
        logic [NGRP:0]   gc;
        logic            term;
        logic            prod;

        r = '0;
        for (int j = 0; j < NGRP; j++) begin
            grp       = cla_group(p[4*j +: 4], g[4*j +: 4], 1'b0);
            grp_pg[j] = grp.pg;
            grp_gg[j] = grp.gg;
        end

        gc[0] = cin;
        term  = 1'b0;
        prod  = 1'b1;
        for (int j = 1; j <= NGRP; j++) begin
            term = 1'b0;
            prod = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                term = term | (grp_gg[i] & prod);
                prod = prod & grp_pg[i];
            end
            gc[j] = term | (prod & cin);
        end
        // After the last pass, term/prod span every group of the segment
        r.gg   = term;
        r.pg   = prod;
        r.cout = gc[NGRP];

        for (int j = 0; j < NGRP; j++) begin
            grp = cla_group(p[4*j +: 4], g[4*j +: 4], gc[j]);
            r.sum[4*j +: 4] = p[4*j +: 4] ^ grp.carry;
            if (j == NGRP - 1) r.msb_cin = grp.carry[3];
        end
        return r;
    endfunction

    // Stage registers: stage k holds the state after segment k is resolved
    logic [NSEG-1:0]  st_valid;
    logic [WIDTH-1:0] st_a   [NSEG];
    logic [WIDTH-1:0] st_b   [NSEG];   // b already conditioned for subtract
    logic [WIDTH-1:0] st_sum [NSEG];
    logic [NSEG-1:0]  st_c;            // carry out of segment k
    logic [NSEG-1:0]  st_pg;
    logic [NSEG-1:0]  st_gg;
    logic             ovf_q;
    logic             zero_q;

    // Inputs seen by each stage (stage 0 from the ports, stage k from stage k-1)
    logic [NSEG-1:0]  src_valid;
    logic [WIDTH-1:0] src_a   [NSEG];
    logic [WIDTH-1:0] src_b   [NSEG];
    logic [WIDTH-1:0] src_sum [NSEG];
    logic [NSEG-1:0]  src_c;
    logic [NSEG-1:0]  src_pg;
    logic [NSEG-1:0]  src_gg;

    // Values each stage will capture on the next advance
    logic [WIDTH-1:0] nxt_sum [NSEG];
    logic [NSEG-1:0]  nxt_c;
    logic [NSEG-1:0]  nxt_pg;
    logic [NSEG-1:0]  nxt_gg;
    logic             fin_msbc;
    logic             fin_zero;
    logic             fin_ovf;

    logic             advance;

    assign out_valid = st_valid[NSEG-1];
    assign in_ready  = ~out_valid | out_ready;
    assign advance   = in_ready;

    // Per-stage segment evaluation, plus the word flags formed in the final stage
    // NOTE: every variable here is assigned unconditionally before any branch reads
    // or refines it, so this block stays purely combinational with no inferred latch.
    always_comb begin
        seg_t seg;
        logic [SEG-1:0] seg_p;
        logic [SEG-1:0] seg_g;

        src_valid[0] = in_valid;
        src_a[0]     = in_a;
        src_b[0]     = in_sub ? ~in_b : in_b;
        src_sum[0]   = '0;
        src_c[0]     = in_cin;
        src_pg[0]    = 1'b1;   // empty word: propagates, generates nothing
        src_gg[0]    = 1'b0;
        for (int k = 1; k < NSEG; k++) begin
            src_valid[k] = st_valid[k-1];
            src_a[k]     = st_a[k-1];
            src_b[k]     = st_b[k-1];
            src_sum[k]   = st_sum[k-1];
            src_c[k]     = st_c[k-1];
            src_pg[k]    = st_pg[k-1];
            src_gg[k]    = st_gg[k-1];
        end

        fin_msbc = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            seg_p = src_a[k][k*SEG +: SEG] ^ src_b[k][k*SEG +: SEG];
            seg_g = src_a[k][k*SEG +: SEG] & src_b[k][k*SEG +: SEG];
            seg   = cla_segment(seg_p, seg_g, src_c[k]);

            nxt_sum[k]                = src_sum[k];
            nxt_sum[k][k*SEG +: SEG]  = seg.sum;
            nxt_c[k]                  = seg.cout;
            nxt_pg[k]                 = src_pg[k] & seg.pg;
            nxt_gg[k]                 = seg.gg | (seg.pg & src_gg[k]);
            if (k == NSEG - 1) fin_msbc = seg.msb_cin;
        end

        fin_zero = (nxt_sum[NSEG-1] == '0);
        fin_ovf  = nxt_c[NSEG-1] ^ fin_msbc;
    end

    // Pipeline advance: all stages move together when the output slot frees up
    // NOTE: all state uses non-blocking assignment so every stage samples the
    // pre-edge value of its predecessor, independent of statement order.
    // NOTE: the datapath is reset along with the valid bits because out_sum and
    // every flag are driven straight from these registers and must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_c     <= '0;
            st_pg    <= '0;
            st_gg    <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                st_a[k]   <= '0;
                st_b[k]   <= '0;
                st_sum[k] <= '0;
            end
        end else if (advance) begin
            st_valid <= src_valid;
            st_c     <= nxt_c;
            st_pg    <= nxt_pg;
            st_gg    <= nxt_gg;
            ovf_q    <= fin_ovf;
            zero_q   <= fin_zero;
            for (int k = 0; k < NSEG; k++) begin
                st_a[k]   <= src_a[k];
                st_b[k]   <= src_b[k];
                st_sum[k] <= nxt_sum[k];
            end
        end
    end

    assign out_sum  = st_sum[NSEG-1];
    assign out_cout = st_c[NSEG-1];
    assign out_pg   = st_pg[NSEG-1];
    assign out_gg   = st_gg[NSEG-1];
    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, SEG=8, two-stage pipeline).
// Expected results come from plain integer arithmetic on a+b_eff+cin; a queue
// scoreboard tracks accepted transactions and their accept cycle.

module tb_cla_pipe_adder;

    localparam int WIDTH = 16;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             pg;
        logic             gg;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_pg;
    logic             out_gg;

    res_t obs;
    assign obs = {out_sum, out_cout, out_ovf, out_zero, out_pg, out_gg};

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rand_ready = 0;
    bit   lat_chk    = 0;
    int   stall_from = 0;
    int   stall_to   = 0;
    res_t exp_q[$];
    int   acc_q[$];

    cla_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_pg    (out_pg),
        .out_gg    (out_gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: word-level arithmetic, no bit-level carry structure
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t             r;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   full;
        logic [WIDTH:0]   nocin;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, cin};
        nocin  = {1'b0, a} + {1'b0, be};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        r.zero = (full[WIDTH-1:0] == '0);
        r.pg   = &(a ^ be);
        r.gg   = nocin[WIDTH];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock cycle, entered and left just after a falling edge
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, output bit acc);
        in_valid = iv;
        in_a     = iv ? a   : 16'($urandom);
        in_b     = iv ? b   : 16'($urandom);
        in_cin   = iv ? cin : 1'($urandom);
        in_sub   = iv ? sub : 1'($urandom);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else            out_ready = !(cyc >= stall_from && cyc < stall_to);
        #1;
        acc = 0;
        if (exp_q.size() == 0) check("idle_valid", out_valid, 0);
        else if (out_valid)    check("result", obs, exp_q[0]);
        if (lat_chk) begin
            if (exp_q.size() != 0) check("valid_timing", out_valid, (cyc - acc_q[0]) == NSEG);
            else                   check("valid_timing", out_valid, 0);
        end
        if (out_valid && !out_ready) check("ready_stall", in_ready, 0);
        else                         check("ready_open", in_ready, 1);
        if (out_valid && out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            acc_q.push_back(cyc);
            acc = 1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        bit acc = 0;
        for (int n = 0; n < 50 && !acc; n++) cycle(1'b1, a, b, cin, sub, acc);
        if (!acc) check("accept_timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit               pend;
        bit               acc;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic             rs;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset state
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_outputs", obs, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Directed boundary vectors, full rate, exact latency
        lat_chk = 1;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h00FF, 16'h0000, 1'b1, 1'b0);
        send(16'h1234, 16'h1234, 1'b1, 1'b1);
        send(16'h0000, 16'h0001, 1'b1, 1'b1);
        drain();

        // Back-to-back stream with a 3-cycle consumer stall mid-stream
        lat_chk    = 0;
        stall_from = cyc + 3;
        stall_to   = cyc + 6;
        for (int i = 0; i < 5; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();
        stall_from = 0;
        stall_to   = 0;

        // Alternating bubbles: results must keep the same spacing
        lat_chk = 1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
            else            cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
        end
        drain();

        // Reset with two transactions in flight
        lat_chk = 0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_outputs", obs, 0);
        check("async_rst_ready", in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        lat_chk = 1;
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure
        lat_chk    = 0;
        rand_ready = 1;
        pend       = 0;
        ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                ra   = rnd_op();
                rb   = rnd_op();
                rc   = 1'($urandom);
                rs   = 1'($urandom);
            end
            cycle(pend, ra, rb, rc, rs, acc);
            if (acc) pend = 0;
        end
        rand_ready = 0;
        drain();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor that supersedes the fixed 8-bit combinational CLA.
- WIDTH-bit operands are split into pipeline segments of SEG bits. Each segment is built from 4-bit CLA groups with group P/G lookahead inside the segment.
- The carry between segments is registered.
- Valid/ready handshake with full backpressure; flags suit an ALU datapath.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG.
- SEG, 8, bits per pipeline segment; must be a multiple of 4.
- Derived NSEG = WIDTH/SEG = pipeline latency in cycles; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in, used as-is in both modes.
- in_sub  in  1  0 = A+B+cin; 1 = A+~B+cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; in subtract mode, 1 = no borrow.
- out_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_zero  out  1  out_sum == 0.
- out_pg  out  1  word group propagate = AND of all bit P (P = a ^ b_eff).
- out_gg  out  1  word group generate = carry out with carry-in forced to 0.

Behaviour:
- b_eff = in_sub ? ~in_b : in_b. Plain subtraction requires in_cin=1; borrow chaining passes the previous out_cout.
- Per bit: G = a & b_eff, P = a ^ b_eff, S = P ^ c.
- Inside a segment:
  - Each 4-bit group computes internal carries from its G/P and the group carry-in.
  - Group carry out = GG | PG & cin. Every bit of every group is included.
  - Segment carry is resolved by lookahead over the groups' PG/GG. No ripple between groups.
- Pipeline structure:
  - Stage k (k = 0..NSEG-1) computes segment k from the carry registered by stage k-1; stage 0 uses in_cin.
  - Operand bits for higher segments are delayed (skewed) alongside the data.
  - Already-computed lower sum bits are carried forward.
  - Running word PG/GG is accumulated per stage: PG_acc &= PG_seg; GG_acc = GG_seg | PG_seg & GG_acc.
  - The final stage register drives all out_* signals.
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+NSEG-1 (NSEG cycles). Throughput is 1 per cycle when unstalled.
- Handshake:
  - Accept occurs when in_valid & in_ready at the rising edge.
  - Result is consumed when out_valid & out_ready.
  - in_ready = ~out_valid | out_ready. This is a global advance enable; every stage register and valid bit moves only when in_ready=1.
  - When stalled, all stage contents and all out_* hold stable.
  - in_ready may depend combinationally on out_ready.
  - Bubbles (in_valid=0 at advance) propagate as valid=0 slots. Order is strictly preserved; no drop or duplication.
- Simultaneous accept and consume in the same cycle is legal and sustains full throughput.
- Stall rules:
  - in_a, in_b, in_cin and in_sub are don't-care while in_valid=0.
  - While in_ready=0, the source holds its transaction until accepted.
- out_zero, out_ovf and out_cout are computed at the final stage, with no extra cycle.
- Reset:
  - rst_n low clears all stage valid bits and drives out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_pg=0, out_gg=0 immediately, asynchronously.
  - In-flight transactions are discarded.
  - in_ready=1 during and after reset.
  - Release is synchronous to clk by integration.
- Boundary cases:
  - 0xFFFF+1 wraps to 0 with cout=1.
  - 0x7FFF+1 sets ovf.
  - Subtracting equal values gives zero=1, cout=1.
  - 0 - 1 gives all-ones, cout=0, ovf=0.
  - NSEG=1 degenerates to one registered stage.

Test Plan:
- WIDTH=16, SEG=8. Add 0x7FFF+0x0001, cin=0 → two cycles later: sum=0x8000, cout=0, ovf=1, zero=0, pg=0, gg=0.
- Add 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, zero=1, ovf=0, gg=1. Add 0x00FF+0x0000, cin=1 → sum=0x0100, cout=0; checks carry crossing the segment register.
- Sub 0x1234-0x1234, cin=1 → sum=0x0000, cout=1, zero=1, ovf=0, pg=1, gg=0. Sub 0x0000-0x0001, cin=1 → sum=0xFFFF, cout=0, ovf=0.
- Stream 5 random transactions back-to-back with out_ready held low for 3 cycles mid-stream:
  - in_ready is low while out_valid=1.
  - outputs stay stable through the stall.
  - all 5 results emerge in order, matching a+b_eff+cin mod 2^16.
- Alternate in_valid 1/0 over 6 cycles with out_ready=1 → results appear with identical bubble spacing; no spurious out_valid.
- Two transactions in flight, pull rst_n low for 1 cycle mid-clock:
  - out_valid and all flags go to 0 immediately.
  - nothing from the pre-reset transactions appears afterwards.
  - a new 0x0001+0x0001 gives 0x0002 after two cycles.
